imm_decode_stage: RTL

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

---
 rtl/imm_decode_stage.sv | 131 +++++++++++++
 1 files changed

// File: rtl/imm_decode_stage.sv
// Immediate decode stage: extracts the RV immediate and branch/jump target,
// then queues the decoded result in a small FIFO toward the next stage.
module imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_tgt,
    output logic            out_illegal
);

    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end
    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $error("imm_decode_stage: DEPTH must be in 1..8");
    end

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_t;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] tgt;
        fmt_t            fmt;
        logic            illegal;
    } entry_t;

    entry_t          dec;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    entry_t          mem [DEPTH];
    logic            push;
    logic            pop;

    // Decode happens before the buffer so the outputs come straight from registers.
    always_comb begin
        dec.fmt = FMT_NONE;
        if (in_inst[1:0] == 2'b11) begin
            unique case (in_inst[6:2])
                5'b00000, 5'b00100, 5'b11001, 5'b11100: dec.fmt = FMT_I;
                5'b00110: dec.fmt = (XLEN == 64) ? FMT_I : FMT_NONE;
                5'b01000: dec.fmt = FMT_S;
                5'b11000: dec.fmt = FMT_B;
                5'b01101, 5'b00101: dec.fmt = FMT_U;
                5'b11011: dec.fmt = FMT_J;
                default:  dec.fmt = FMT_NONE;
            endcase
        end
        unique case (dec.fmt)
            FMT_I:   dec.imm = XLEN'($signed(in_inst[31:20]));
            FMT_S:   dec.imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
            FMT_B:   dec.imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                              in_inst[11:8], 1'b0}));
            FMT_U:   dec.imm = XLEN'($signed({in_inst[31:12], 12'b0}));
            FMT_J:   dec.imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                              in_inst[30:21], 1'b0}));
            default: dec.imm = '0;
        endcase
        dec.illegal = (dec.fmt == FMT_NONE);
        dec.tgt     = in_pc + dec.imm;
    end

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // in_ready looks only at registered count, so a pop never frees a slot in the same cycle.
    assign in_ready  = (count < CW'(DEPTH)) && !rst;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; count gates visibility,
    // so stale contents are never presented and the array maps to plain flops/RAM.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= dec;
    end

    always_comb begin
        out_imm     = '0;
        out_fmt     = 3'd0;
        out_tgt     = '0;
        out_illegal = 1'b0;
        if (out_valid) begin
            out_imm     = mem[rd_ptr].imm;
            out_fmt     = mem[rd_ptr].fmt;
            out_tgt     = mem[rd_ptr].tgt;
            out_illegal = mem[rd_ptr].illegal;
        end
    end

endmodule
